// File: rtl/sid_mixer_n.sv
// sid_mixer_n -- multi-voice audio mixer with filter routing, bypass mute,
// DC offset and master volume.
//
// A sample strobe (clkEn) snapshots all voice amplitudes, then a small
// sequencer accumulates one voice per clock into either the filter path or
// the bypass path, combines the bypass sum with the selected filter outputs
// and a DC offset, and finally scales the result by a 4-bit master volume.
//
// Ports:
//   clk         master clock
//   iRstN       asynchronous active-low reset
//   clkEn       sample strobe; starts a mix sequence when idle
//   iWE/iAddr/iDataW   register write port
//   oDataR      combinational register read data
//   iVoices     NUM_VOICES packed signed 16-bit voices, voice k at [16k+15:16k]
//   oPreFilter  saturated sum of voices routed to the filter
//   iFiltLP/BP/HP  signed filter outputs, sampled in the post-mix cycle
//   oOut        mixed, volume-scaled output
//   oValid      one-cycle pulse when oOut updates
//   oBusy       sequencer active
//
// Register map (relative to BASE_ADDR):
//   +0 ROUTE mask   +1 {MUTE3, MODE[2:0], VOL[3:0]}   +2 MUTE mask
//   +3 STATUS {7'b0, OVERRUN}, write clears OVERRUN
//   any other address reads back the last written byte.
module sid_mixer_n #(
    parameter int         NUM_VOICES = 3,
    parameter int         HEADROOM   = 3,
    parameter logic [4:0] BASE_ADDR  = 5'h17,
    parameter int         DC_OFFSET  = -7489
) (
    input  logic                       clk,
    input  logic                       iRstN,
    input  logic                       clkEn,
    input  logic                       iWE,
    input  logic [4:0]                 iAddr,
    input  logic [7:0]                 iDataW,
    output logic [7:0]                 oDataR,
    input  logic [NUM_VOICES*16-1:0]   iVoices,
    output logic signed [15:0]         oPreFilter,
    input  logic signed [15:0]         iFiltLP,
    input  logic signed [15:0]         iFiltBP,
    input  logic signed [15:0]         iFiltHP,
    output logic signed [15:0]         oOut,
    output logic                       oValid,
    output logic                       oBusy
);

    // Accumulators are wide enough to sum every voice without overflow.
    localparam int AW = 16 + $clog2(NUM_VOICES) + 1;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [4:0] A_ROUTE = BASE_ADDR;
    localparam logic [4:0] A_CTRL  = BASE_ADDR + 5'd1;
    localparam logic [4:0] A_MUTE  = BASE_ADDR + 5'd2;
    localparam logic [4:0] A_STAT  = BASE_ADDR + 5'd3;

    localparam logic signed [AW-1:0] AMAX = AW'(32767);
    localparam logic signed [AW-1:0] AMIN = AW'(-32768);
    localparam logic signed [19:0]   PMAX = 20'sd32767;
    localparam logic signed [19:0]   PMIN = -20'sd32768;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_POST, S_VOL} state_t;

    state_t state, nxt;

    // Control registers
    logic [NUM_VOICES-1:0] route;
    logic [NUM_VOICES-1:0] mute;
    logic                  mute3;
    logic [2:0]            mode;
    logic [3:0]            vol;
    logic [7:0]            last_wr;
    logic                  overrun;

    // Datapath
    logic [NUM_VOICES-1:0][15:0] snap;
    logic [IW-1:0]               idx;
    logic signed [AW-1:0]        flt_acc, byp_acc;
    logic signed [15:0]          psat;

    logic signed [15:0]   cur;
    logic signed [AW-1:0] cur_x, sh;
    logic                 last, eff_mute;
    logic signed [19:0]   post_sum;
    logic signed [15:0]   pre_sat, post_sat;
    logic signed [20:0]   prod;

    // ---------------- register file ----------------
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            route   <= '0;
            mute    <= '0;
            mute3   <= 1'b0;
            mode    <= 3'd0;
            vol     <= 4'hF;
            last_wr <= 8'd0;
            overrun <= 1'b0;
        end else begin
            if (iWE) begin
                last_wr <= iDataW;
                case (iAddr)
                    A_ROUTE: route <= iDataW[NUM_VOICES-1:0];
                    A_CTRL:  {mute3, mode, vol} <= iDataW;
                    A_MUTE:  mute <= iDataW[NUM_VOICES-1:0];
                    default: ;
                endcase
            end
            // A strobe that arrives mid-sequence wins over a clearing write.
            if (clkEn && state != S_IDLE)
                overrun <= 1'b1;
            else if (iWE && iAddr == A_STAT)
                overrun <= 1'b0;
        end
    end

    always_comb begin
        oDataR = last_wr;
        case (iAddr)
            A_ROUTE: oDataR = 8'(route);
            A_CTRL:  oDataR = {mute3, mode, vol};
            A_MUTE:  oDataR = 8'(mute);
            A_STAT:  oDataR = {7'b0, overrun};
            default: ;
        endcase
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) state <= S_IDLE;
        else        state <= nxt;
    end

    assign last = (idx == IW'(NUM_VOICES - 1));

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  if (clkEn) nxt = S_ACCUM;
            S_ACCUM: if (last)  nxt = S_POST;
            S_POST:  nxt = S_VOL;
            S_VOL:   nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state != S_IDLE);
    end

    // ---------------- datapath ----------------
    assign cur      = snap[idx];
    assign cur_x    = {{(AW-16){cur[15]}}, cur};
    assign sh       = cur_x >>> HEADROOM;
    // MUTE3 is a legacy alias that mutes the highest voice on the bypass path.
    assign eff_mute = mute[idx] | (mute3 & last);

    assign post_sum = 20'(byp_acc)
                    + (mode[0] ? 20'(iFiltLP) : 20'sd0)
                    + (mode[1] ? 20'(iFiltBP) : 20'sd0)
                    + (mode[2] ? 20'(iFiltHP) : 20'sd0)
                    + 20'(DC_OFFSET);

    assign pre_sat  = (flt_acc > AMAX) ? 16'sh7FFF :
                      (flt_acc < AMIN) ? 16'sh8000 : flt_acc[15:0];
    assign post_sat = (post_sum > PMAX) ? 16'sh7FFF :
                      (post_sum < PMIN) ? 16'sh8000 : post_sum[15:0];

    // VOL is unsigned; zero-extend so the multiply stays signed.
    assign prod = 21'(psat) * 21'($signed({1'b0, vol}));

    always_ff @(posedge clk or negedge iRstN) begin
        if (!iRstN) begin
            snap       <= '0;
            idx        <= '0;
            flt_acc    <= '0;
            byp_acc    <= '0;
            psat       <= '0;
            oPreFilter <= '0;
            oOut       <= '0;
            oValid     <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (state)
                S_IDLE: if (clkEn) begin
                    snap    <= iVoices;
                    flt_acc <= '0;
                    byp_acc <= '0;
                    idx     <= '0;
                end
                S_ACCUM: begin
                    if (route[idx])     flt_acc <= flt_acc + sh;
                    else if (!eff_mute) byp_acc <= byp_acc + sh;
                    idx <= idx + IW'(1);
                end
                S_POST: begin
                    oPreFilter <= pre_sat;
                    psat       <= post_sat;
                end
                S_VOL: begin
                    oOut   <= 16'(prod >>> 4);
                    oValid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sid_mixer_n.sv
// Directed bench for sid_mixer_n. Two instances share the register bus:
// u0 (3 voices, headroom 3, no DC offset) and u1 (8 voices, no headroom,
// default DC offset).
module tb_sid_mixer_n;

    localparam logic [4:0] BASE = 5'h17;
    localparam logic [4:0] CTRL = 5'h18;
    localparam logic [4:0] MUTE = 5'h19;
    localparam logic [4:0] STAT = 5'h1A;

    logic               clk, rst_n;
    logic               clk_en0, clk_en1;
    logic               we;
    logic [4:0]         addr;
    logic [7:0]         wdata;
    logic [47:0]        voices0;
    logic [127:0]       voices1;
    logic signed [15:0] filt_lp, filt_bp, filt_hp;

    logic [7:0]         rd0, rd1;
    logic signed [15:0] pre0, pre1, out0, out1;
    logic               vld0, vld1, busy0, busy1;

    int checks = 0;
    int errors = 0;

    sid_mixer_n #(.NUM_VOICES(3), .HEADROOM(3), .BASE_ADDR(5'h17), .DC_OFFSET(0)) u0 (
        .clk(clk), .iRstN(rst_n), .clkEn(clk_en0), .iWE(we), .iAddr(addr), .iDataW(wdata),
        .oDataR(rd0), .iVoices(voices0), .oPreFilter(pre0),
        .iFiltLP(filt_lp), .iFiltBP(filt_bp), .iFiltHP(filt_hp),
        .oOut(out0), .oValid(vld0), .oBusy(busy0));

    sid_mixer_n #(.NUM_VOICES(8), .HEADROOM(0), .BASE_ADDR(5'h17), .DC_OFFSET(-7489)) u1 (
        .clk(clk), .iRstN(rst_n), .clkEn(clk_en1), .iWE(we), .iAddr(addr), .iDataW(wdata),
        .oDataR(rd1), .iVoices(voices1), .oPreFilter(pre1),
        .iFiltLP(filt_lp), .iFiltBP(filt_bp), .iFiltHP(filt_hp),
        .oOut(out1), .oValid(vld1), .oBusy(busy1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic set_regs(input logic [7:0] r, input logic [7:0] c, input logic [7:0] m);
        wr(BASE, r);
        wr(CTRL, c);
        wr(MUTE, m);
    endtask

    // Pulse clkEn for one cycle; lat = negedges from strobe drive to oValid.
    task automatic run0(output int lat);
        clk_en0 = 1'b1;
        @(negedge clk);
        clk_en0 = 1'b0;
        lat = 1;
        while (vld0 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run1(output int lat);
        clk_en1 = 1'b1;
        @(negedge clk);
        clk_en1 = 1'b0;
        lat = 1;
        while (vld1 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        checks++; if (out0 !== 16'sd0) begin errors++; $display("FAIL rst_out: got %0d expected 0", out0); end
        checks++; if (pre0 !== 16'sd0) begin errors++; $display("FAIL rst_pre: got %0d expected 0", pre0); end
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", vld0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy0); end
        addr = CTRL; #1;
        checks++; if (rd0 !== 8'h0F) begin errors++; $display("FAIL rst_ctrl: got %h expected 0f", rd0); end
        addr = BASE; #1;
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL rst_route: got %h expected 00", rd0); end
        addr = MUTE; #1;
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL rst_mute: got %h expected 00", rd0); end
        addr = STAT; #1;
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL rst_status: got %h expected 00", rd0); end
        addr = 5'h00; #1;
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL rst_lastwr: got %h expected 00", rd0); end
    endtask

    task automatic test_basic;
        int lat;
        set_regs(8'h00, 8'h0F, 8'h00);
        voices0 = {3{16'sd8000}};
        run0(lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL basic_latency: got %0d expected 6", lat); end
        checks++; if (out0 !== 16'sd2812) begin errors++; $display("FAIL basic_out: got %0d expected 2812", out0); end
        checks++; if (pre0 !== 16'sd0) begin errors++; $display("FAIL basic_pre: got %0d expected 0", pre0); end
        @(negedge clk);
        checks++; if (vld0 !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", vld0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b expected 0", busy0); end
    endtask

    task automatic test_route_mode;
        int lat;
        set_regs(8'h05, 8'h1F, 8'h00);
        filt_lp = 16'sd1000;
        voices0 = {16'sd2400, 16'sd1600, 16'sd800};
        run0(lat);
        checks++; if (pre0 !== 16'sd400) begin errors++; $display("FAIL route_pre: got %0d expected 400", pre0); end
        checks++; if (out0 !== 16'sd1125) begin errors++; $display("FAIL route_out: got %0d expected 1125", out0); end
        // BP + HP selected, LP present but not selected: 3000 + 300 - 100 = 3200
        set_regs(8'h00, 8'h6F, 8'h00);
        filt_bp = 16'sd300;
        filt_hp = -16'sd100;
        voices0 = {3{16'sd8000}};
        run0(lat);
        checks++; if (out0 !== 16'sd3000) begin errors++; $display("FAIL mode_bphp_out: got %0d expected 3000", out0); end
        filt_lp = 16'sd0; filt_bp = 16'sd0; filt_hp = 16'sd0;
    endtask

    task automatic test_mute;
        int lat;
        voices0 = {3{16'sd8000}};
        set_regs(8'h00, 8'h8F, 8'h00);
        addr = CTRL; #1;
        checks++; if (rd0 !== 8'h8F) begin errors++; $display("FAIL mute3_read: got %h expected 8f", rd0); end
        run0(lat);
        checks++; if (out0 !== 16'sd1875) begin errors++; $display("FAIL mute3_out: got %0d expected 1875", out0); end
        // MUTE3 does not affect a voice routed to the filter
        set_regs(8'h04, 8'h8F, 8'h00);
        run0(lat);
        checks++; if (pre0 !== 16'sd1000) begin errors++; $display("FAIL mute3_route_pre: got %0d expected 1000", pre0); end
        checks++; if (out0 !== 16'sd1875) begin errors++; $display("FAIL mute3_route_out: got %0d expected 1875", out0); end
        // Mask mutes voice 0 on bypass
        set_regs(8'h00, 8'h0F, 8'h01);
        run0(lat);
        checks++; if (out0 !== 16'sd1875) begin errors++; $display("FAIL mask_out: got %0d expected 1875", out0); end
        // Mask does not apply to routed voice 0
        set_regs(8'h01, 8'h0F, 8'h01);
        run0(lat);
        checks++; if (pre0 !== 16'sd1000) begin errors++; $display("FAIL mask_route_pre: got %0d expected 1000", pre0); end
        checks++; if (out0 !== 16'sd1875) begin errors++; $display("FAIL mask_route_out: got %0d expected 1875", out0); end
    endtask

    task automatic test_volume;
        int lat;
        set_regs(8'h00, 8'h08, 8'h00);
        voices0 = {3{16'sd8000}};
        run0(lat);
        checks++; if (out0 !== 16'sd1500) begin errors++; $display("FAIL vol8_out: got %0d expected 1500", out0); end
        set_regs(8'h00, 8'h00, 8'h00);
        run0(lat);
        checks++; if (out0 !== 16'sd0) begin errors++; $display("FAIL vol0_out: got %0d expected 0", out0); end
        // -3000 * 15 = -45000, arithmetic >>> 4 floors to -2813
        set_regs(8'h00, 8'h0F, 8'h00);
        voices0 = {3{-16'sd8000}};
        run0(lat);
        checks++; if (out0 !== -16'sd2813) begin errors++; $display("FAIL neg_out: got %0d expected -2813", out0); end
    endtask

    task automatic test_mid_write;
        int lat;
        set_regs(8'h00, 8'h0F, 8'h00);
        voices0 = {3{16'sd8000}};
        clk_en0 = 1'b1;
        @(negedge clk);
        clk_en0 = 1'b0;
        // Lands on the edge that accumulates voice 0, so only voices 1,2 see it
        we = 1'b1; addr = MUTE; wdata = 8'h07;
        @(negedge clk);
        we = 1'b0;
        lat = 2;
        while (vld0 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (lat != 6) begin errors++; $display("FAIL midwr_latency: got %0d expected 6", lat); end
        checks++; if (out0 !== 16'sd937) begin errors++; $display("FAIL midwr_out: got %0d expected 937", out0); end
    endtask

    task automatic test_overrun;
        int pulses;
        set_regs(8'h00, 8'h0F, 8'h00);
        voices0 = {3{16'sd8000}};
        clk_en0 = 1'b1;
        @(negedge clk);
        clk_en0 = 1'b0;
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL ovr_busy: got %b expected 1", busy0); end
        @(negedge clk);
        clk_en0 = 1'b1;
        @(negedge clk);
        clk_en0 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            if (vld0 === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", pulses); end
        checks++; if (out0 !== 16'sd2812) begin errors++; $display("FAIL ovr_out: got %0d expected 2812", out0); end
        addr = STAT; #1;
        checks++; if (rd0 !== 8'h01) begin errors++; $display("FAIL ovr_status: got %h expected 01", rd0); end
        @(negedge clk);
        wr(STAT, 8'h5A);
        addr = STAT; #1;
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL ovr_clear: got %h expected 00", rd0); end
        addr = 5'h00; #1;
        checks++; if (rd0 !== 8'h5A) begin errors++; $display("FAIL lastwr_read: got %h expected 5a", rd0); end
        @(negedge clk);
        // Clear write coinciding with an overrun strobe: overrun wins
        clk_en0 = 1'b1;
        @(negedge clk);
        clk_en0 = 1'b0;
        @(negedge clk);
        clk_en0 = 1'b1; we = 1'b1; addr = STAT; wdata = 8'h00;
        @(negedge clk);
        clk_en0 = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) @(negedge clk);
        addr = STAT; #1;
        checks++; if (rd0 !== 8'h01) begin errors++; $display("FAIL ovr_simul: got %h expected 01", rd0); end
        @(negedge clk);
        wr(STAT, 8'h00);
    endtask

    task automatic test_wide;
        int lat;
        set_regs(8'h00, 8'h0F, 8'h00);
        voices1 = {8{16'sh7FFF}};
        run1(lat);
        checks++; if (lat != 11) begin errors++; $display("FAIL wide_latency: got %0d expected 11", lat); end
        checks++; if (out1 !== 16'sd30719) begin errors++; $display("FAIL wide_pos_sat: got %0d expected 30719", out1); end
        voices1 = {8{16'sh8000}};
        run1(lat);
        checks++; if (out1 !== -16'sd30720) begin errors++; $display("FAIL wide_neg_sat: got %0d expected -30720", out1); end
        // 8000 - 7489 = 511, *15 >>> 4 = 479
        voices1 = {8{16'sd1000}};
        run1(lat);
        checks++; if (out1 !== 16'sd479) begin errors++; $display("FAIL wide_dc_out: got %0d expected 479", out1); end
        // All routed: pre-filter saturates, bypass is just DC offset
        set_regs(8'hFF, 8'h0F, 8'h00);
        voices1 = {8{16'sh7FFF}};
        run1(lat);
        checks++; if (pre1 !== 16'sd32767) begin errors++; $display("FAIL wide_pre_pos: got %0d expected 32767", pre1); end
        checks++; if (out1 !== -16'sd7021) begin errors++; $display("FAIL wide_dc_only: got %0d expected -7021", out1); end
        voices1 = {8{16'sh8000}};
        run1(lat);
        checks++; if (pre1 !== -16'sd32768) begin errors++; $display("FAIL wide_pre_neg: got %0d expected -32768", pre1); end
    endtask

    task automatic test_reset_mid;
        int lat, pulses;
        set_regs(8'h00, 8'h08, 8'h00);
        voices0 = {3{16'sd8000}};
        run0(lat);
        checks++; if (out0 !== 16'sd1500) begin errors++; $display("FAIL rmid_pre_out: got %0d expected 1500", out0); end
        @(negedge clk);
        clk_en0 = 1'b1;
        @(negedge clk);
        clk_en0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        addr = CTRL; #1;
        checks++; if (out0 !== 16'sd0) begin errors++; $display("FAIL rmid_out: got %0d expected 0", out0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy0); end
        checks++; if (rd0 !== 8'h0F) begin errors++; $display("FAIL rmid_vol: got %h expected 0f", rd0); end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (vld0 === 1'b1) pulses++;
            @(negedge clk);
        end
        checks++; if (pulses != 0) begin errors++; $display("FAIL rmid_novalid: got %0d expected 0", pulses); end
        run0(lat);
        checks++; if (lat != 6) begin errors++; $display("FAIL rmid_fresh_lat: got %0d expected 6", lat); end
        checks++; if (out0 !== 16'sd2812) begin errors++; $display("FAIL rmid_fresh_out: got %0d expected 2812", out0); end
    endtask

    initial begin
        rst_n = 1'b0;
        clk_en0 = 1'b0; clk_en1 = 1'b0;
        we = 1'b0; addr = 5'h00; wdata = 8'h00;
        voices0 = '0; voices1 = '0;
        filt_lp = 16'sd0; filt_bp = 16'sd0; filt_hp = 16'sd0;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_route_mode;
        test_mute;
        test_volume;
        test_mid_write;
        test_overrun;
        test_wide;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sid_mixer_n.md
SID_MIXER_N -- requirements
Module: sid_mixer_n

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 3, voice count (1..8).
REQ-002 SHALL have parameter HEADROOM, default 3, arithmetic right shift applied to each voice before summing.
REQ-003 SHALL have parameter BASE_ADDR, default 5'h17, first register address.
REQ-004 SHALL have parameter DC_OFFSET, default -7489, signed constant added in post-mix.
REQ-005 SHALL have ports:
  clk  in  1  master clock
  iRstN  in  1  reset: asynchronous, active-low
  clkEn  in  1  sample strobe (1 MHz enable)
  iWE  in  1  register write enable
  iAddr  in  5  register address
  iDataW  in  8  write data
  oDataR  out  8  read data (combinational)
  iVoices  in  NUM_VOICES*16  signed voice amplitudes; voice k at [16k+15:16k]
  oPreFilter  out  16  signed filter-input sum
  iFiltLP / iFiltBP / iFiltHP  in  16 each  signed filter outputs
  oOut  out  16  signed mixed output after master volume
  oValid  out  1  one-cycle pulse when oOut updates
  oBusy  out  1  sequencer not IDLE

Function
REQ-006 Registers SHALL be: BASE+0 ROUTE[NUM_VOICES-1:0] (1 = voice to filter); BASE+1 {MUTE3, MODE[2:0], VOL[3:0]}; BASE+2 MUTE mask[NUM_VOICES-1:0] (bypass path only); BASE+3 STATUS, read-only {7'b0, OVERRUN}.
REQ-007 Any write SHALL update an 8-bit last-write register; write to BASE+3 SHALL clear OVERRUN.
REQ-008 Reads SHALL return register contents (unused bits 0) at BASE+0..BASE+3, else last-write value.
REQ-009 Effective bypass mute for the last voice SHALL be MUTE[NUM_VOICES-1] | MUTE3.
REQ-010 Sequencer states SHALL be IDLE, ACCUM, POST, VOL.
REQ-011 IDLE: on clkEn, capture iVoices into a snapshot register, clear both accumulators, voice index 0, go ACCUM.
REQ-012 ACCUM: one voice per clk; shifted voice added to filter accumulator if ROUTE[k], else to bypass accumulator if not muted, else discarded; after index NUM_VOICES-1 go POST.
REQ-013 Accumulators SHALL be 16+clog2(NUM_VOICES)+1 bits signed; no intermediate saturation.
REQ-014 POST: oPreFilter <= filter accumulator saturated to [-32768, 32767]; post-sum <= bypass + MODE[0]·LP + MODE[1]·BP + MODE[2]·HP + DC_OFFSET, 20-bit signed, then saturated to 16 bits; filter inputs sampled this cycle; go VOL.
REQ-015 VOL: oOut <= (saturated post-sum × VOL) >>> 4 (arithmetic), oValid = 1 for this single cycle; go IDLE.
REQ-016 Latency clkEn to oValid SHALL be NUM_VOICES+3 clk cycles.
REQ-017 clkEn while not IDLE SHALL be ignored and SHALL set OVERRUN (sticky).
REQ-018 Register writes SHALL take effect the following clk; a write mid-ACCUM affects only voices not yet accumulated.
REQ-019 Simultaneous clear-write to BASE+3 and overrun SHALL leave OVERRUN = 1.
REQ-020 oBusy SHALL be 1 in ACCUM, POST, VOL.

Reset
REQ-021 iRstN low SHALL asynchronously force: state IDLE, oOut 0, oPreFilter 0, oValid 0, accumulators 0, ROUTE 0, MUTE 0, MUTE3 0, MODE 0, VOL 4'hF, last-write 0, OVERRUN 0.
REQ-022 Reset mid-sequence SHALL abort with no oValid; first clkEn after release starts a fresh sequence.

Verification
REQ-023 NUM_VOICES=3, ROUTE=0, VOL=15, DC_OFFSET=0, voices 8000 each, clkEn -> oValid exactly 6 clks later, oOut = (3000*15)>>>4 = 2812, oPreFilter 0.
REQ-024 ROUTE=3'b101, MODE=3'b001, LP=1000, voices 800/1600/2400 -> oPreFilter 400, post-sum 200+1000=1200, oOut 1125.
REQ-025 Voices 32767 each, NUM_VOICES=8, HEADROOM=0, VOL=15 -> post-sum saturates to 32767, oOut 30719; negative case 32768 -> -30720.
REQ-026 MUTE3=1, ROUTE=0, voices 8000 each -> voice 2 excluded, oOut = (2000*15)>>>4 = 1875.
REQ-027 clkEn again 2 clks into sequence -> ignored, STATUS reads 8'h01, single oValid; write BASE+3 -> STATUS 8'h00.
REQ-028 iRstN low during ACCUM -> oValid never asserted, VOL reads 4'hF, oOut 0 immediately.
